alu_sequencer: RTL

Control-side counterpart of the combinational ALU: fetches 16-bit instructions over a req/ack port, decodes them, and drives the ALU opcode, shift-direction and operand inputs. Captures the ALU result into a 4-entry register file and sequences LOAD/STORE/OUT/JUMP/HALT. Sits between program memory, data memory, the output port and the ALU inside the CPU core.

---
 rtl/alu_sequencer_pkg.sv | 47 ++++
 rtl/alu_seq_regfile.sv | 44 ++++
 rtl/alu_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared types for the ALU sequencer: opcodes, instruction layout and FSM states.
package alu_sequencer_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_XOR    = 4'd4,
        OP_SHIFT  = 4'd5,
        OP_LOAD   = 4'd6,
        OP_STORE  = 4'd7,
        OP_MOVE   = 4'd8,
        OP_JUMP   = 4'd9,
        OP_LOADC  = 4'd10,
        OP_OUT    = 4'd11,
        OP_UNDEF3 = 4'd12,
        OP_UNDEF4 = 4'd13,
        OP_HALT   = 4'd14,
        OP_NOP    = 4'd15
    } opcode_e;

    // Instruction word layout, MSB first: opcode, rA, imm_sel, shift_dir, imm8.
    typedef struct packed {
        opcode_e    opcode;
        logic [1:0] ra;
        logic       imm_sel;
        logic       shift_dir;
        logic [7:0] imm8;
    } instr_t;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_EXECUTE = 2'd1,
        ST_MEM     = 2'd2,
        ST_HALTED  = 2'd3
    } state_e;

    localparam instr_t NOP_INSTR = '{opcode: OP_NOP, ra: 2'd0, imm_sel: 1'b0,
                                     shift_dir: 1'b0, imm8: 8'd0};

    // Opcodes whose result comes back from the ALU and is written to rA.
    function automatic logic is_alu_op(input opcode_e op);
        return (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHIFT, OP_MOVE});
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Four-entry register file: two asynchronous read ports, one synchronous write port.
module alu_seq_regfile
    import alu_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_we,
    input  logic [1:0]            i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [1:0]            i_raddr_a,
    output logic [DATA_WIDTH-1:0] o_rdata_a,
    input  logic [1:0]            i_raddr_b,
    output logic [DATA_WIDTH-1:0] o_rdata_b
);

    logic [DATA_WIDTH-1:0] regs_q [4];
    logic [DATA_WIDTH-1:0] regs_d [4];

    // Next register contents: only the addressed entry changes on a write.
    always_comb begin
        regs_d = regs_q;
        if (i_we) begin
            regs_d[i_waddr] = i_wdata;
        end
    end

    // Register storage.
    // NOTE: this is four flops per bit, not a RAM macro, so resetting every
    // entry is cheap and gives a defined architectural state after reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            regs_q <= '{default: '0};
        end else begin
            // NOTE: non-blocking so all flops update together at the edge.
            regs_q <= regs_d;
        end
    end

    assign o_rdata_a = regs_q[i_raddr_a];
    assign o_rdata_b = regs_q[i_raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Control sequencer for the combinational ALU: fetch, decode, execute, memory access.
// Optional build macro ALU_SEQ_ILLEGAL_TRAP_EN: undefined opcodes set a sticky
// o_illegal flag and halt; without it they behave as NOP and o_illegal is 0.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int PC_WIDTH   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    output logic [PC_WIDTH-1:0]   o_pc,
    output logic                  o_fetch_req,
    input  logic                  i_fetch_ack,
    input  logic [15:0]           i_instr,
    output logic [3:0]            o_alu_opcode,
    output logic                  o_alu_shift_dir,
    output logic [DATA_WIDTH-1:0] o_alu_data1,
    output logic [DATA_WIDTH-1:0] o_alu_data2,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_out_valid,
    output logic                  o_halted,
    output logic                  o_illegal
);

    state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    instr_t                ir_q, ir_d;
    logic                  started_q, started_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  illegal_q, illegal_d;

    logic                  rf_we;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic [DATA_WIDTH-1:0] rdata_a, rdata_b;
    logic [DATA_WIDTH-1:0] imm_ext, operand2;
    logic [PC_WIDTH-1:0]   pc_inc;

    alu_seq_regfile #(.DATA_WIDTH(DATA_WIDTH)) u_regfile (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_we      (rf_we),
        .i_waddr   (ir_q.ra),
        .i_wdata   (rf_wdata),
        .i_raddr_a (ir_q.ra),
        .o_rdata_a (rdata_a),
        .i_raddr_b (ir_q.imm8[1:0]),
        .o_rdata_b (rdata_b)
    );

    assign imm_ext  = {{(DATA_WIDTH-8){1'b0}}, ir_q.imm8};
    assign operand2 = ir_q.imm_sel ? imm_ext : rdata_b;
    assign pc_inc   = pc_q + PC_WIDTH'(1);

    // Next-state, PC, instruction latch and register-write decisions.
    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        started_d   = 1'b1;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        illegal_d   = illegal_q;
        rf_we       = 1'b0;
        rf_wdata    = i_alu_result;

        unique case (state_q)
            ST_FETCH: begin
                if (started_q && i_fetch_ack) begin
                    ir_d    = instr_t'(i_instr);
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                if (is_alu_op(ir_q.opcode)) begin
                    rf_we = 1'b1;
                end
                case (ir_q.opcode)
                    OP_LOADC: begin
                        rf_we    = 1'b1;
                        rf_wdata = imm_ext;
                    end
                    OP_JUMP: pc_d = operand2[PC_WIDTH-1:0];
                    OP_OUT: begin
                        out_data_d  = rdata_a;
                        out_valid_d = 1'b1;
                    end
                    OP_LOAD, OP_STORE: begin
                        state_d = ST_MEM;
                        pc_d    = pc_q;
                    end
                    OP_HALT: begin
                        state_d = ST_HALTED;
                        pc_d    = pc_q;
                    end
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                    OP_UNDEF3, OP_UNDEF4: begin
                        illegal_d = 1'b1;
                        state_d   = ST_HALTED;
                        pc_d      = pc_q;
                    end
`endif
                    default: ;
                endcase
            end
            ST_MEM: begin
                if (i_mem_ack) begin
                    if (ir_q.opcode == OP_LOAD) begin
                        rf_we    = 1'b1;
                        rf_wdata = i_mem_rdata;
                    end
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end
            end
            ST_HALTED: ;
            default: state_d = ST_FETCH;
        endcase
    end

    // Sequencer state registers; reset leaves a NOP in the instruction register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_FETCH;
            pc_q        <= '0;
            ir_q        <= NOP_INSTR;
            started_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            started_q   <= started_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
        end
    end

    // Port drive: ALU and memory buses are only live in their own states.
    always_comb begin
        o_pc            = pc_q;
        o_fetch_req     = started_q && (state_q == ST_FETCH);
        o_alu_opcode    = started_q ? OP_NOP : 4'd0;
        o_alu_shift_dir = 1'b0;
        o_alu_data1     = '0;
        o_alu_data2     = '0;
        o_mem_req       = 1'b0;
        o_mem_we        = 1'b0;
        o_mem_addr      = '0;
        o_mem_wdata     = '0;
        o_out_data      = out_data_q;
        o_out_valid     = out_valid_q;
        o_halted        = (state_q == ST_HALTED);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        o_illegal       = illegal_q;
`else
        o_illegal       = 1'b0;
`endif
        if (state_q == ST_EXECUTE) begin
            o_alu_opcode    = ir_q.opcode;
            o_alu_shift_dir = ir_q.shift_dir;
            o_alu_data1     = rdata_a;
            o_alu_data2     = operand2;
        end
        if (state_q == ST_MEM) begin
            o_mem_req   = 1'b1;
            o_mem_we    = (ir_q.opcode == OP_STORE);
            o_mem_addr  = operand2;
            o_mem_wdata = rdata_a;
        end
    end

    // illegal_q only reaches a port when the trap is built in.
`ifndef ALU_SEQ_ILLEGAL_TRAP_EN
    logic unused_illegal;
    assign unused_illegal = illegal_q;
`endif

endmodule
